dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder for the pipelined MIPS core's MEM-stage port. Accepts the core's data requests (enable, per-byte write enables, byte address, write data) and serves them from an internal word-organised RAM.
- Returns registered read data with a valid strobe.
- Inserts a configurable number of wait states by driving a stall back to the pipeline hazard logic.
- Flags out-of-range accesses.

Parameters:
- ADDR_W, 10, word-address width; RAM depth = 2**ADDR_W 32-bit words.
- WAIT_CYCLES, 0, wait states per access, range 0..7; 0 = single-cycle memory, no stall.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  request strobe from MEM stage.
- wen  input  4  byte write enables; wen[0]=bits 7:0 … wen[3]=bits 31:24; 4'b0000 = read.
- addr  input  32  byte address (ALU result in MEM).
- wdata  input  32  write data, already lane-aligned by requester.
- rdata  output  32  registered read data.
- rvalid  output  1  one-cycle pulse: rdata updated by a completed read.
- stall  output  1  combinational; requester must hold request and freeze the pipeline while high.
- err  output  1  one-cycle pulse: completed access was out of range.

Behaviour:
- Reset values: rdata=0, rvalid=0, err=0, FSM=IDLE, counter=0, latched request cleared. RAM contents are not cleared by reset.
- Address decode:
  - word index = addr[ADDR_W+1:2]; addr[1:0] ignored (no alignment check).
  - in range iff addr[31:ADDR_W+2]==0.
  - Out-of-range write: RAM unchanged. Out-of-range read: rdata<=0, rvalid<=1. Both pulse err for one cycle, aligned with the completion cycle.
- Access semantics:
  - Write: only bytes with wen bit set are updated; other bytes are preserved. Write produces no rvalid and leaves rdata unchanged.
  - Read: rdata<=RAM[word]; rvalid=1 for exactly one cycle.
  - rdata holds its value between reads.
- FSM, states IDLE and BUSY:
  - IDLE, en=1, WAIT_CYCLES=0: access performed at this edge; rvalid/err visible next cycle; stay IDLE.
  - IDLE, en=1, WAIT_CYCLES>0: latch addr/wen/wdata; counter<=WAIT_CYCLES-1; go BUSY.
  - BUSY, counter!=0: counter decrements.
  - BUSY, counter==0: perform the latched access at this edge; go IDLE.
  - en is ignored in BUSY. Live inputs in BUSY never affect the access; only latched values are used.
- stall = (IDLE & en & WAIT_CYCLES!=0) | (BUSY & counter!=0).
  - For a request first presented in cycle T, stall is high for cycles T..T+WAIT_CYCLES-1 (exactly WAIT_CYCLES cycles).
  - The access completes at the end of cycle T+WAIT_CYCLES; rvalid/err are high in cycle T+WAIT_CYCLES+1.
- Back-to-back requests: a new request is accepted in the first IDLE cycle after completion. There is no pipelining of requests in the wait-state configuration.
- Read-after-write to the same word in consecutive accepted requests returns the newly written bytes, because accesses are strictly sequential.
- Reset during BUSY: pending access aborted; no RAM write, no rvalid, stall low in the cycle after reset.
- en=0 in IDLE: no state change; rvalid/err return to 0.

Test Plan:
- WAIT_CYCLES=0: write wen=4'hF, addr=0x10, wdata=0xDEADBEEF; then read addr=0x10 -> rdata=0xDEADBEEF with rvalid=1 one cycle after the read request, stall never high.
- Byte lanes: after the above, write wen=4'b0010, addr=0x12, wdata=0x0000AA00; read 0x10 -> 0xDEADAAEF (addr[1:0] ignored, only bits 15:8 changed).
- WAIT_CYCLES=3: read presented in cycle T -> stall high T..T+2, rvalid high only in T+4. Changing addr during T+1..T+3 does not change returned data.
- Out of range, ADDR_W=10: write to 0x00001000 -> err pulse, RAM word 0 unchanged. Read 0x00001000 -> rdata=0, rvalid=1, err=1 same cycle.
- Reset mid-access, WAIT_CYCLES=2: write issued, rst asserted in the BUSY cycle -> target word retains its old value, stall=0 and rvalid=0 after reset, rdata=0.
- Sequential writes then reads to 0x0, 0x4, 0xFFC (top word) -> each read returns its own data; no aliasing at the top of the RAM.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder for the MIPS MEM-stage port: word-organised RAM with byte
// write enables, registered read data, optional wait states and out-of-range flagging.
module dmem_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [3:0]  wen,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic        stall,
    output logic        err
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    localparam logic [2:0] CNT_INIT = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;

    state_t             state_q;
    logic [2:0]         count_q;
    logic [3:0]         reqWen_q;
    logic [31:0]        reqAddr_q;
    logic [31:0]        reqWdata_q;
    logic [31:0]        rdata_q;
    logic               rvalid_q;
    logic               err_q;

    logic [31:0]        mem [0:(1 << ADDR_W) - 1];

    logic               doAccess_d;
    logic [3:0]         accWen_d;
    logic [31:0]        accAddr_d;
    logic [31:0]        accWdata_d;
    logic [ADDR_W-1:0]  accIdx_d;
    logic               accInRange_d;
    logic               accIsRead_d;
    logic [1:0]         unusedAddrLsb;

    // In BUSY the live bus is ignored; the access always uses the latched request.
    always_comb begin
        doAccess_d   = ((state_q == IDLE) && en && (WAIT_CYCLES == 0)) ||
                       ((state_q == BUSY) && (count_q == 3'd0));
        accWen_d     = (state_q == BUSY) ? reqWen_q   : wen;
        accAddr_d    = (state_q == BUSY) ? reqAddr_q  : addr;
        accWdata_d   = (state_q == BUSY) ? reqWdata_q : wdata;
        accIdx_d     = accAddr_d[ADDR_W+1:2];
        accInRange_d = (accAddr_d[31:ADDR_W+2] == '0);
        accIsRead_d  = (accWen_d == 4'b0000);
    end

    assign unusedAddrLsb = accAddr_d[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= 3'd0;
            reqWen_q   <= 4'b0000;
            reqAddr_q  <= 32'h0;
            reqWdata_q <= 32'h0;
            rdata_q    <= 32'h0;
            rvalid_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            rvalid_q <= doAccess_d && accIsRead_d;
            err_q    <= doAccess_d && !accInRange_d;
            if (doAccess_d && accIsRead_d) begin
                rdata_q <= accInRange_d ? mem[accIdx_d] : 32'h0;
            end
            case (state_q)
                IDLE: begin
                    if (en && (WAIT_CYCLES != 0)) begin
                        reqWen_q   <= wen;
                        reqAddr_q  <= addr;
                        reqWdata_q <= wdata;
                        count_q    <= CNT_INIT;
                        state_q    <= BUSY;
                    end
                end
                BUSY: begin
                    if (count_q != 3'd0) begin
                        count_q <= count_q - 3'd1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // RAM has no reset; a reset edge must still suppress a pending write.
    always_ff @(posedge clk) begin
        if (!rst && doAccess_d && accInRange_d) begin
            for (int b = 0; b < 4; b++) begin
                if (accWen_d[b]) begin
                    mem[accIdx_d][8*b +: 8] <= accWdata_d[8*b +: 8];
                end
            end
        end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
    assign err    = err_q;
    assign stall  = ((state_q == IDLE) && en && (WAIT_CYCLES != 0)) ||
                    ((state_q == BUSY) && (count_q != 3'd0));

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (0, 2 and 3 wait states) driven by a
// directed vector table, reset-abort sequences and random traffic against a memory model.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        en     [3];
    logic [3:0]  wen    [3];
    logic [31:0] addr   [3];
    logic [31:0] wdata  [3];
    logic [31:0] rdata  [3];
    logic        rvalid [3];
    logic        stall  [3];
    logic        err    [3];

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .en(en[0]), .wen(wen[0]), .addr(addr[0]), .wdata(wdata[0]),
        .rdata(rdata[0]), .rvalid(rvalid[0]), .stall(stall[0]), .err(err[0]));

    dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) dut1 (
        .clk(clk), .rst(rst), .en(en[1]), .wen(wen[1]), .addr(addr[1]), .wdata(wdata[1]),
        .rdata(rdata[1]), .rvalid(rvalid[1]), .stall(stall[1]), .err(err[1]));

    dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(3)) dut2 (
        .clk(clk), .rst(rst), .en(en[2]), .wen(wen[2]), .addr(addr[2]), .wdata(wdata[2]),
        .rdata(rdata[2]), .rvalid(rvalid[2]), .stall(stall[2]), .err(err[2]));

    typedef struct {
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] expRead;
        logic        expErr;
    } vec_t;

    vec_t        vecs [16];
    int          nChecks = 0;
    int          nFails  = 0;
    logic [31:0] expRd  [3];
    logic        expRv  [3];
    logic        expErr [3];
    logic [31:0] model [int];

    function automatic int wcOf(int k);
        return (k == 0) ? 0 : (k == 1) ? 2 : 3;
    endfunction

    function automatic int keyOf(int k, logic [31:0] a);
        return k * 4096 + int'(a[11:2]);
    endfunction

    task automatic check(string name, int k, logic [31:0] got, logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("[TB] FAIL %s dut%0d got=%h expected=%h", name, k, got, exp);
        end
    endtask

    // Registered outputs reflect whatever access completed at the previous edge.
    task automatic checkOutput(int k);
        check("rvalid", k, 32'(rvalid[k]), 32'(expRv[k]));
        check("err",    k, 32'(err[k]),    32'(expErr[k]));
        check("rdata",  k, rdata[k],       expRd[k]);
    endtask

    task automatic applyStimulus(int k, logic [3:0] w, logic [31:0] a, logic [31:0] d,
                                 bit scramble, logic [31:0] expRead, logic expE);
        logic [31:0] word;
        @(negedge clk);
        en[k] = 1'b1; wen[k] = w; addr[k] = a; wdata[k] = d;
        #1;
        checkOutput(k);
        for (int c = 0; c < wcOf(k); c++) begin
            check("stall_high", k, 32'(stall[k]), 32'd1);
            @(negedge clk);
            if (scramble) begin
                wen[k]   = 4'($urandom);
                addr[k]  = $urandom;
                wdata[k] = $urandom;
            end
            #1;
        end
        check("stall_low", k, 32'(stall[k]), 32'd0);
        expErr[k] = expE;
        expRv[k]  = (w == 4'b0000);
        if (w == 4'b0000) begin
            expRd[k] = expE ? 32'h0 : expRead;
        end else if (!expE) begin
            word = model.exists(keyOf(k, a)) ? model[keyOf(k, a)] : 32'h0;
            for (int b = 0; b < 4; b++) begin
                if (w[b]) word[8*b +: 8] = d[8*b +: 8];
            end
            model[keyOf(k, a)] = word;
        end
    endtask

    task automatic idleCycle(int k);
        @(negedge clk);
        en[k] = 1'b0;
        #1;
        checkOutput(k);
        check("stall_idle", k, 32'(stall[k]), 32'd0);
        expRv[k]  = 1'b0;
        expErr[k] = 1'b0;
    endtask

    // Start a full-word write, then hit reset after `delay` further cycles.
    task automatic resetMidAccess(int k, int delay, logic [31:0] a, logic [31:0] d);
        @(negedge clk);
        en[k] = 1'b1; wen[k] = 4'hF; addr[k] = a; wdata[k] = d;
        #1;
        check("stall_pre_rst", k, 32'(stall[k]), 32'd1);
        repeat (delay) @(negedge clk);
        rst = 1'b1;
        en[k] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int j = 0; j < 3; j++) begin
            expRd[j] = 32'h0; expRv[j] = 1'b0; expErr[j] = 1'b0;
        end
        check("stall_post_rst", k, 32'(stall[k]), 32'd0);
        checkOutput(k);
    endtask

    function automatic logic [31:0] modelRead(int k, logic [31:0] a);
        return model[keyOf(k, a)];
    endfunction

    initial begin
        logic [31:0] pool [8];
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  w;
        int          r;

        vecs[0]  = '{4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         1'b0};
        vecs[1]  = '{4'h0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{4'h2, 32'h0000_0012, 32'h0000_AA00, 32'h0,         1'b0};
        vecs[3]  = '{4'h0, 32'h0000_0010, 32'h0,         32'hDEAD_AAEF, 1'b0};
        vecs[4]  = '{4'hF, 32'h0000_0000, 32'h1111_1111, 32'h0,         1'b0};
        vecs[5]  = '{4'hF, 32'h0000_0004, 32'h2222_2222, 32'h0,         1'b0};
        vecs[6]  = '{4'hF, 32'h0000_0FFC, 32'h3333_3333, 32'h0,         1'b0};
        vecs[7]  = '{4'h0, 32'h0000_0000, 32'h0,         32'h1111_1111, 1'b0};
        vecs[8]  = '{4'h0, 32'h0000_0004, 32'h0,         32'h2222_2222, 1'b0};
        vecs[9]  = '{4'h0, 32'h0000_0FFC, 32'h0,         32'h3333_3333, 1'b0};
        vecs[10] = '{4'hF, 32'h0000_1000, 32'hFFFF_FFFF, 32'h0,         1'b1};
        vecs[11] = '{4'h0, 32'h0000_1000, 32'h0,         32'h0,         1'b1};
        vecs[12] = '{4'h0, 32'h0000_0000, 32'h0,         32'h1111_1111, 1'b0};
        vecs[13] = '{4'h1, 32'h0000_0003, 32'h0000_00AB, 32'h0,         1'b0};
        vecs[14] = '{4'h0, 32'h0000_0000, 32'h0,         32'h1111_11AB, 1'b0};
        vecs[15] = '{4'h0, 32'h8000_0010, 32'h0,         32'h0,         1'b1};

        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            en[k] = 1'b0; wen[k] = 4'h0; addr[k] = 32'h0; wdata[k] = 32'h0;
            expRd[k] = 32'h0; expRv[k] = 1'b0; expErr[k] = 1'b0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            checkOutput(k);
            check("stall_reset", k, 32'(stall[k]), 32'd0);
        end

        // Directed table, back-to-back, live bus scrambled while waiting.
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 16; i++) begin
                applyStimulus(k, vecs[i].wen, vecs[i].addr, vecs[i].wdata, k != 0,
                              vecs[i].expRead, vecs[i].expErr);
            end
            idleCycle(k);
        end

        // Reset in first BUSY cycle (dut1) and in the final BUSY cycle (dut2).
        applyStimulus(1, 4'hF, 32'h40, 32'hCAFE_F00D, 1'b0, 32'h0, 1'b0);
        idleCycle(1);
        resetMidAccess(1, 1, 32'h40, 32'h1234_5678);
        applyStimulus(1, 4'h0, 32'h40, 32'h0, 1'b0, 32'hCAFE_F00D, 1'b0);
        idleCycle(1);

        applyStimulus(2, 4'hF, 32'h80, 32'h0BAD_CAFE, 1'b0, 32'h0, 1'b0);
        idleCycle(2);
        resetMidAccess(2, 3, 32'h80, 32'h5555_AAAA);
        applyStimulus(2, 4'h0, 32'h80, 32'h0, 1'b0, 32'h0BAD_CAFE, 1'b0);
        idleCycle(2);

        // Random traffic over a small pool of in-range words.
        for (int k = 0; k < 3; k++) begin
            pool[0] = 32'h0;
            pool[1] = 32'hFFC;
            for (int p = 2; p < 8; p++) pool[p] = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
            for (int p = 0; p < 8; p++) begin
                applyStimulus(k, 4'hF, pool[p], $urandom, 1'b0, 32'h0, 1'b0);
            end
            for (int n = 0; n < 60; n++) begin
                r = $urandom_range(0, 9);
                a = pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
                if (r == 0) begin
                    idleCycle(k);
                end else if (r == 1) begin
                    a = $urandom | 32'h0000_1000;
                    w = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                    applyStimulus(k, w, a, $urandom, 1'b1, 32'h0, 1'b1);
                end else if (r <= 5) begin
                    applyStimulus(k, 4'h0, a, 32'h0, 1'b1, modelRead(k, a), 1'b0);
                end else begin
                    d = $urandom;
                    w = 4'($urandom_range(1, 15));
                    applyStimulus(k, w, a, d, 1'b1, 32'h0, 1'b0);
                end
            end
            idleCycle(k);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
